// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Shared definitions for the video capture block: capture state
//               encoding, grayscale coefficients, RGB field offsets and the
//               RGB-to-gray helper.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_VSYNC = 2'd0,
        ST_CAPTURE    = 2'd1,
        ST_DROP       = 2'd2
    } state_e;

    // The coefficients add up to 256, so the >>8 normalises the luma weights.
    localparam logic [15:0] GRAY_R = 16'd77;
    localparam logic [15:0] GRAY_G = 16'd150;
    localparam logic [15:0] GRAY_B = 16'd29;

    localparam int PIX_R_LSB = 16;
    localparam int PIX_G_LSB = 8;
    localparam int PIX_B_LSB = 0;

    // The largest sum is 256*255 = 65280, so 16 bits never overflow.
    function automatic logic [7:0] rgb_to_gray(input logic [23:0] rgb);
        logic [15:0] sum;
        sum = GRAY_R * {8'd0, rgb[PIX_R_LSB +: 8]}
            + GRAY_G * {8'd0, rgb[PIX_G_LSB +: 8]}
            + GRAY_B * {8'd0, rgb[PIX_B_LSB +: 8]};
        return sum[15:8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : video_capture_if
// Description : Bundles the incoming raster (pData/pHSync/pVSync/pVDE) and the
//               outgoing grayscale valid/ready stream.
//               master : capture side (consumes raster, drives the stream)
//               slave  : environment side (drives raster, consumes stream)
// Revision    : 1.0 - initial release
// ============================================================================
interface video_capture_if;
    logic [23:0] pData;
    logic        pHSync;
    logic        pVSync;
    logic        pVDE;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;

    modport master (
        input  pData, pHSync, pVSync, pVDE, dout_ready,
        output dout, dout_valid
    );

    modport slave (
        output pData, pHSync, pVSync, pVDE, dout_ready,
        input  dout, dout_valid
    );
endinterface
`default_nettype wire

// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
// Module      : fifo
// Description : Synchronous first-word-fall-through FIFO.
//   clk, rst                    clock, synchronous active-high reset
//   enq_valid_i/enq_ready_o     write handshake, enq_data_i write data
//   deq_valid_o/deq_ready_i     read handshake, deq_data_o head of queue
// Revision    : 1.0 - initial release
// ============================================================================
module fifo #(
    parameter int WIDTH    = 8,
    parameter int LOGDEPTH = 10
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             enq_valid_i,
    output logic                  enq_ready_o,
    input  wire logic [WIDTH-1:0] enq_data_i,
    output logic                  deq_valid_o,
    input  wire logic             deq_ready_i,
    output logic [WIDTH-1:0]      deq_data_o
);
    localparam int DEPTH = 1 << LOGDEPTH;

    logic [WIDTH-1:0]  mem_q [0:DEPTH-1];
    logic [LOGDEPTH-1:0] wr_ptr_q;
    logic [LOGDEPTH-1:0] rd_ptr_q;
    logic [LOGDEPTH:0]   count_q;
    logic [LOGDEPTH:0]   count_d;
    logic                enq_fire;
    logic                deq_fire;

    assign deq_valid_o = (count_q != '0);
    assign deq_fire    = deq_valid_o & deq_ready_i;
    // A slot freed by a read in the same cycle can be refilled immediately.
    assign enq_ready_o = ~count_q[LOGDEPTH] | deq_ready_i;
    assign enq_fire    = enq_valid_i & enq_ready_o;
    // Masked so the output reads zero whenever nothing is queued.
    assign deq_data_o  = deq_valid_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        count_d = count_q;
        if (enq_fire && !deq_fire) begin
            count_d = count_q + 1'b1;
        end else if (!enq_fire && deq_fire) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (enq_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (deq_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) mem_q[wr_ptr_q] <= enq_data_i;
    end
endmodule
`default_nettype wire

// File: rtl/video_capture.sv
`default_nettype none
// ============================================================================
// Module      : video_capture
// Description : Frame-aligned capture of an RGB raster into an 8-bit grayscale
//               valid/ready stream through an internal FIFO. A frame is either
//               captured whole or dropped from the first pixel that finds the
//               FIFO full; capture only ever starts at a VSync rising edge.
// Ports       : pixel_clk   sole clock
//               rst         synchronous active-high reset
//               capture_en  arms capture, sampled at VSync rising edges
//               vif         raster in / grayscale stream out (master modport)
//               frame_done  one-cycle pulse at the end of a clean frame
//               overflow    sticky, set on any dropped pixel
// Options     : VIDEO_CAPTURE_STATS_EN adds frame_count, drop_count and
//               line_count outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module video_capture
    import video_pkg::*;
#(
    parameter int FIFO_LOGDEPTH = 10,
    parameter int FIFO_WIDTH    = 8
) (
    input  wire logic           pixel_clk,
    input  wire logic           rst,
    input  wire logic           capture_en,
    video_capture_if.master     vif,
    output logic                frame_done,
    output logic                overflow
`ifdef VIDEO_CAPTURE_STATS_EN
    ,
    output logic [15:0]         frame_count,
    output logic [15:0]         drop_count,
    output logic [11:0]         line_count
`endif
);
    state_e          state_q, state_d;
    logic            vsync_q;
    logic            vs_rise;
    logic            pix_valid_q, pix_valid_d;
    logic [7:0]      gray_q, gray_d;
    logic            frame_done_q, frame_done_d;
    logic            overflow_q, overflow_d;
    logic            drop_enter;
    logic            load;
    logic            enq_ready;

    assign vs_rise = vif.pVSync & ~vsync_q;

    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        drop_enter   = 1'b0;
        case (state_q)
            ST_WAIT_VSYNC: begin
                if (vs_rise && capture_en) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (pix_valid_q && !enq_ready) begin
                    drop_enter = 1'b1;
                    overflow_d = 1'b1;
                    state_d    = ST_DROP;
                end
                // A drop in the frame's final cycle still spoils that frame,
                // but the edge must still start (or not) the next one.
                if (vs_rise) begin
                    frame_done_d = ~drop_enter;
                    state_d      = capture_en ? ST_CAPTURE : ST_WAIT_VSYNC;
                end
            end
            ST_DROP: begin
                if (vs_rise) state_d = capture_en ? ST_CAPTURE : ST_WAIT_VSYNC;
            end
            default: state_d = ST_WAIT_VSYNC;
        endcase

        // A VDE pixel in the VSync rising cycle belongs to the new frame, so
        // loading keys off the state being entered rather than the current one.
        load        = vif.pVDE && (state_d == ST_CAPTURE);
        pix_valid_d = load;
        gray_d      = load ? rgb_to_gray(vif.pData) : gray_q;
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q      <= ST_WAIT_VSYNC;
            vsync_q      <= 1'b0;
            pix_valid_q  <= 1'b0;
            gray_q       <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vif.pVSync;
            pix_valid_q  <= pix_valid_d;
            gray_q       <= gray_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

    // The stage is never held: a pixel that cannot enter the FIFO is dropped.
    fifo #(
        .WIDTH    (FIFO_WIDTH),
        .LOGDEPTH (FIFO_LOGDEPTH)
    ) u_fifo (
        .clk         (pixel_clk),
        .rst         (rst),
        .enq_valid_i (pix_valid_q),
        .enq_ready_o (enq_ready),
        .enq_data_i  (gray_q),
        .deq_valid_o (vif.dout_valid),
        .deq_ready_i (vif.dout_ready),
        .deq_data_o  (vif.dout)
    );

`ifdef VIDEO_CAPTURE_STATS_EN
    logic        hsync_q;
    logic [15:0] frame_count_q;
    logic [15:0] drop_count_q;
    logic [11:0] line_count_q;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hsync_q       <= 1'b0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
            line_count_q  <= '0;
        end else begin
            hsync_q <= vif.pHSync;
            if (frame_done_d) frame_count_q <= frame_count_q + 1'b1;
            if (drop_enter)   drop_count_q  <= drop_count_q + 1'b1;
            if (vs_rise) begin
                line_count_q <= '0;
            end else if (vif.pHSync && !hsync_q) begin
                line_count_q <= line_count_q + 1'b1;
            end
        end
    end

    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;
    assign line_count  = line_count_q;
`else
    // HSync only feeds the statistics counters.
    logic unused_hsync;
    assign unused_hsync = vif.pHSync;
`endif
endmodule
`default_nettype wire

// File: tb/tb_video_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_capture
// Description : Self-checking bench for video_capture: directed scenarios plus
//               randomized frames, checked every cycle against a queue-based
//               model of the capture rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_capture;
    localparam int LOGDEPTH = 4;
    localparam int DEPTH    = 1 << LOGDEPTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic capture_en;
    logic frame_done;
    logic overflow;
    video_capture_if vif();
`ifdef VIDEO_CAPTURE_STATS_EN
    logic [15:0] frame_count;
    logic [15:0] drop_count;
    logic [11:0] line_count;
`endif

    video_capture #(.FIFO_LOGDEPTH(LOGDEPTH), .FIFO_WIDTH(8)) dut (
        .pixel_clk  (clk),
        .rst        (rst),
        .capture_en (capture_en),
        .vif        (vif),
        .frame_done (frame_done),
        .overflow   (overflow)
`ifdef VIDEO_CAPTURE_STATS_EN
        ,
        .frame_count(frame_count),
        .drop_count (drop_count),
        .line_count (line_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray_of(input logic [23:0] p);
        return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
    endfunction

    // ---------------- reference model ----------------
    int m_q[$];
    bit m_cap, m_ovf, m_fd, m_vs_prev, m_hs_prev, m_stage_v;
    int m_stage_px, m_fc, m_dc, m_lc;

    always @(posedge clk) begin : model
        bit vs_rise, hs_rise, dropnow, clean;
        if (rst) begin
            m_q.delete();
            m_cap = 0; m_ovf = 0; m_fd = 0; m_vs_prev = 0; m_hs_prev = 0;
            m_stage_v = 0; m_stage_px = 0; m_fc = 0; m_dc = 0; m_lc = 0;
        end else begin
            vs_rise = vif.pVSync && !m_vs_prev;
            hs_rise = vif.pHSync && !m_hs_prev;
            if (m_q.size() > 0 && vif.dout_ready) void'(m_q.pop_front());
            dropnow = 0;
            if (m_stage_v) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_stage_px);
                else dropnow = 1;
            end
            clean = m_cap && !dropnow;
            m_fd  = 0;
            if (dropnow) begin
                m_ovf = 1;
                m_dc  = (m_dc + 1) % 65536;
                m_cap = 0;
            end
            if (vs_rise) begin
                if (clean) begin
                    m_fd = 1;
                    m_fc = (m_fc + 1) % 65536;
                end
                m_cap = capture_en;
                m_lc  = 0;
            end else if (hs_rise) begin
                m_lc = (m_lc + 1) % 4096;
            end
            m_stage_v  = vif.pVDE && m_cap;
            m_stage_px = gray_of(vif.pData);
            m_vs_prev  = vif.pVSync;
            m_hs_prev  = vif.pHSync;
        end
    end

    // ---------------- per-cycle compare ----------------
    int  out_log[$];
    int  fd_cnt = 0;
    bit  prev_valid = 0, prev_ready = 0, prev_rst = 1;
    int  prev_dout = 0;

    always @(negedge clk) begin : compare
        chk("valid", int'(vif.dout_valid), int'(m_q.size() > 0));
        if (m_q.size() > 0) chk("dout", int'(vif.dout), m_q[0]);
        chk("frame_done", int'(frame_done), int'(m_fd));
        chk("overflow", int'(overflow), int'(m_ovf));
`ifdef VIDEO_CAPTURE_STATS_EN
        chk("frame_count", int'(frame_count), m_fc);
        chk("drop_count", int'(drop_count), m_dc);
        chk("line_count", int'(line_count), m_lc);
`endif
        if (prev_valid && !prev_ready && !prev_rst) begin
            chk("hold_valid", int'(vif.dout_valid), 1);
            chk("hold_dout", int'(vif.dout), prev_dout);
        end
        if (!rst && vif.dout_valid && vif.dout_ready) out_log.push_back(int'(vif.dout));
        if (frame_done) fd_cnt++;
        prev_valid = vif.dout_valid;
        prev_ready = vif.dout_ready;
        prev_rst   = rst;
        prev_dout  = int'(vif.dout);
    end

    // ---------------- stimulus ----------------
    bit rnd_mode = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_mode) vif.dout_ready = ($urandom % 3) != 0;
        end
    endtask

    task automatic vsync_pulse();
        vif.pVDE = 0; vif.pHSync = 0; vif.pVSync = 1;
        tick(2);
        vif.pVSync = 0;
        tick(2);
    endtask

    logic [23:0] tab[4];

    task automatic send_pixels(input int n, input bit use_tab, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom % 4) == 0) begin
                vif.pVDE = 0; vif.pHSync = 0;
                tick(1);
            end
            vif.pHSync = (i % 8) == 0;
            vif.pData  = (use_tab && i < 4) ? tab[i] : 24'($urandom);
            vif.pVDE   = 1;
            tick(1);
        end
        vif.pVDE = 0; vif.pHSync = 0;
    endtask

    int fd0;

    initial begin
        rst = 1; capture_en = 0;
        vif.pData = '0; vif.pHSync = 0; vif.pVSync = 0; vif.pVDE = 0; vif.dout_ready = 1;
        tick(3);
        rst = 0;
        chk("reset_valid", int'(vif.dout_valid), 0);
        chk("reset_dout", int'(vif.dout), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_frame_done", int'(frame_done), 0);

        // Colour conversion
        tab[0] = 24'hFFFFFF; tab[1] = 24'hFF0000; tab[2] = 24'h00FF00; tab[3] = 24'h0000FF;
        capture_en = 1;
        out_log.delete();
        fd0 = fd_cnt;
        vsync_pulse();
        send_pixels(4, 1, 0);
`ifdef VIDEO_CAPTURE_STATS_EN
        #4;
        chk("lines_4px", int'(line_count), 1);
`endif
        tick(4);
        vsync_pulse();
        tick(2);
        chk("color_count", out_log.size(), 4);
        chk("gray_white", out_log.size() > 0 ? out_log[0] : -1, 255);
        chk("gray_red",   out_log.size() > 1 ? out_log[1] : -1, 76);
        chk("gray_green", out_log.size() > 2 ? out_log[2] : -1, 149);
        chk("gray_blue",  out_log.size() > 3 ? out_log[3] : -1, 28);
        chk("color_frame_done", fd_cnt - fd0, 1);
`ifdef VIDEO_CAPTURE_STATS_EN
        chk("frame_count_1", int'(frame_count), 1);
`endif

        // Arming mid-frame has no effect until the next VSync edge
        capture_en = 0;
        vsync_pulse();
        tick(3);
        out_log.delete();
        send_pixels(4, 0, 0);
        capture_en = 1;
        send_pixels(4, 0, 0);
        tick(3);
        chk("arm_no_output", out_log.size(), 0);
        vsync_pulse();
        tab[0] = 24'h102030;
        send_pixels(2, 1, 0);
        tick(5);
        chk("arm_first_pixel", out_log.size() > 0 ? out_log[0] : -1, 29);

        // Backpressure without loss
        vif.dout_ready = 0;
        vsync_pulse();
        out_log.delete();
        send_pixels(16, 0, 0);
        tick(40);
        vif.dout_ready = 1;
        tick(20);
        chk("bp_count", out_log.size(), 16);
        chk("bp_overflow", int'(overflow), 0);

        // Overflow drops the rest of the frame
        vif.dout_ready = 0;
        vsync_pulse();
        out_log.delete();
        fd0 = fd_cnt;
        send_pixels(24, 0, 0);
        vsync_pulse();
        chk("ovf_no_frame_done", fd_cnt - fd0, 0);
        chk("ovf_sticky", int'(overflow), 1);
`ifdef VIDEO_CAPTURE_STATS_EN
        chk("drop_count_1", int'(drop_count), 1);
`endif
        vif.dout_ready = 1;
        tick(25);
        chk("ovf_delivered", out_log.size(), DEPTH);
        send_pixels(5, 0, 0);
        tick(3);
        fd0 = fd_cnt;
        vsync_pulse();
        chk("ovf_next_frame_done", fd_cnt - fd0, 1);

        // Reset mid-frame, then a disabled VSync edge
        vif.dout_ready = 0;
        send_pixels(3, 0, 0);
        tick(2);
        rst = 1;
        tick(1);
        chk("rst_valid", int'(vif.dout_valid), 0);
        chk("rst_overflow", int'(overflow), 0);
        rst = 0;
        capture_en = 0;
        vif.dout_ready = 1;
        out_log.delete();
        vsync_pulse();
        send_pixels(6, 0, 0);
        tick(4);
        chk("disabled_no_capture", out_log.size(), 0);

        // Randomized frames with random stalls
        rnd_mode = 1;
        for (int f = 0; f < 60; f++) begin
            capture_en = ($urandom % 4) != 0;
            vsync_pulse();
            send_pixels($urandom_range(0, 30), 0, 1);
            tick($urandom_range(0, 6));
        end
        rnd_mode = 0;
        vif.dout_ready = 1;
        tick(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
